// File: rtl/lsu_axi_pkg.sv
// Shared LSU definitions: op/size/error codes, AXI response codes, FSM states
// and the alignment rule used when a request is accepted.
package riscv_lsu_pkg;

    typedef enum logic [1:0] {
        LSU_OP_NONE  = 2'b00,
        LSU_OP_LOAD  = 2'b01,
        LSU_OP_STORE = 2'b10,
        LSU_OP_RSVD  = 2'b11
    } lsu_op_e;

    typedef enum logic [1:0] {
        LSU_SIZE_B = 2'd0,
        LSU_SIZE_H = 2'd1,
        LSU_SIZE_W = 2'd2,
        LSU_SIZE_D = 2'd3
    } lsu_size_e;

    typedef enum logic [1:0] {
        LSU_ERR_OK       = 2'b00,
        LSU_ERR_MISALIGN = 2'b01,
        LSU_ERR_BUS      = 2'b10,
        LSU_ERR_TIMEOUT  = 2'b11
    } lsu_err_e;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
    localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE, ST_RADDR, ST_RDATA, ST_WREQ, ST_WRESP, ST_RESP, ST_DRAIN
    } lsu_state_e;

    // dword accesses are only legal on a 64-bit bus
    function automatic logic lsu_misaligned(input logic [1:0] size,
                                            input logic [2:0] addr_lo,
                                            input logic       dword_ok);
        case (lsu_size_e'(size))
            LSU_SIZE_B: return 1'b0;
            LSU_SIZE_H: return addr_lo[0];
            LSU_SIZE_W: return |addr_lo[1:0];
            default:    return !dword_ok || (|addr_lo);
        endcase
    endfunction

endpackage

// File: rtl/lsu_axi_align.sv
// Combinational lane logic: store data replication / byte strobes, and load
// lane extraction with sign or zero extension.
module lsu_align
    import riscv_lsu_pkg::*;
#(
    parameter  int unsigned DATA_W = 32,
    localparam int unsigned NB     = DATA_W / 8,
    localparam int unsigned OFF_W  = $clog2(NB)
) (
    input  logic [1:0]        size_i,
    input  logic [OFF_W-1:0]  offset_i,
    input  logic              unsigned_i,
    input  logic [DATA_W-1:0] st_data_i,
    output logic [DATA_W-1:0] st_data_o,
    output logic [NB-1:0]     st_strb_o,
    input  logic [DATA_W-1:0] ld_data_i,
    output logic [DATA_W-1:0] ld_data_o
);

    logic [7:0]        strb_base;
    logic [NB-1:0]     strb_mask;
    logic [DATA_W-1:0] shifted;
    logic              ext_bit;
    int unsigned       width;

    always_comb begin
        case (lsu_size_e'(size_i))
            LSU_SIZE_B: begin st_data_o = {NB{st_data_i[7:0]}};       strb_base = 8'h01; end
            LSU_SIZE_H: begin st_data_o = {(NB/2){st_data_i[15:0]}};  strb_base = 8'h03; end
            LSU_SIZE_W: begin st_data_o = {(NB/4){st_data_i[31:0]}};  strb_base = 8'h0F; end
            default:    begin st_data_o = st_data_i;                  strb_base = 8'hFF; end
        endcase
        strb_mask = strb_base[NB-1:0];
        st_strb_o = strb_mask << offset_i;
    end

    always_comb begin
        shifted = ld_data_i >> {offset_i, 3'b000};
        case (lsu_size_e'(size_i))
            LSU_SIZE_B: begin width = 8;  ext_bit = shifted[7];  end
            LSU_SIZE_H: begin width = 16; ext_bit = shifted[15]; end
            LSU_SIZE_W: begin width = 32; ext_bit = shifted[31]; end
            default:    begin width = DATA_W; ext_bit = shifted[DATA_W-1]; end
        endcase
        ext_bit   = ext_bit && !unsigned_i;
        ld_data_o = shifted;
        for (int unsigned i = 0; i < DATA_W; i++) begin
            if (i >= width) ld_data_o[i] = ext_bit;
        end
    end

endmodule

// File: rtl/lsu_axi.sv
// Load/store unit mastering all five AXI4-Lite channels, with misalignment,
// bus-error and response-timeout reporting and a drain state for late beats.
module lsu_axi
    import riscv_lsu_pkg::*;
#(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned TAG_W   = 119,
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                req_valid_i,
    output logic                req_ready_o,
    input  logic [1:0]          req_op_i,
    input  logic [1:0]          req_size_i,
    input  logic                req_unsigned_i,
    input  logic [ADDR_W-1:0]   req_addr_i,
    input  logic [DATA_W-1:0]   req_wdata_i,
    input  logic [DATA_W-1:0]   req_result_i,
    input  logic [TAG_W-1:0]    req_tag_i,
    output logic                resp_valid_o,
    input  logic                resp_ready_i,
    output logic [DATA_W-1:0]   resp_data_o,
    output logic [TAG_W-1:0]    resp_tag_o,
    output logic [1:0]          resp_err_o,
    output logic [ADDR_W-1:0]   araddr_o,
    output logic                arvalid_o,
    input  logic                arready_i,
    input  logic [DATA_W-1:0]   rdata_i,
    input  logic [1:0]          rresp_i,
    input  logic                rvalid_i,
    output logic                rready_o,
    output logic [ADDR_W-1:0]   awaddr_o,
    output logic                awvalid_o,
    input  logic                awready_i,
    output logic [DATA_W-1:0]   wdata_o,
    output logic [DATA_W/8-1:0] wstrb_o,
    output logic                wvalid_o,
    input  logic                wready_i,
    input  logic [1:0]          bresp_i,
    input  logic                bvalid_i,
    output logic                bready_o
);

    localparam int unsigned STRB_W = DATA_W / 8;
    localparam int unsigned OFF_W  = $clog2(STRB_W);
    localparam int unsigned TMR_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    lsu_state_e         state_q, state_d;
    logic               req_ready_q, req_ready_d;
    logic               arvalid_q, arvalid_d, rready_q, rready_d;
    logic               awvalid_q, awvalid_d, wvalid_q, wvalid_d, bready_q, bready_d;
    logic               resp_valid_q, resp_valid_d;
    logic [1:0]         size_q, size_d;
    logic               uns_q, uns_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [DATA_W-1:0]  wdata_q, wdata_d, data_q, data_d;
    logic [TAG_W-1:0]   tag_q, tag_d;
    lsu_err_e           err_q, err_d;
    logic [TMR_W-1:0]   timer_q, timer_d;

    lsu_op_e            op;
    logic               aw_done, w_done, beat, timeout_hit, r_err, b_err;
    logic [DATA_W-1:0]  ld_data;

    lsu_align #(.DATA_W(DATA_W)) u_align (
        .size_i     (size_q),
        .offset_i   (addr_q[OFF_W-1:0]),
        .unsigned_i (uns_q),
        .st_data_i  (wdata_q),
        .st_data_o  (wdata_o),
        .st_strb_o  (wstrb_o),
        .ld_data_i  (rdata_i),
        .ld_data_o  (ld_data)
    );

    always_comb begin
        state_d      = state_q;
        req_ready_d  = req_ready_q;
        arvalid_d    = arvalid_q;
        rready_d     = rready_q;
        awvalid_d    = awvalid_q;
        wvalid_d     = wvalid_q;
        bready_d     = bready_q;
        resp_valid_d = resp_valid_q;
        size_d       = size_q;
        uns_d        = uns_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        data_d       = data_q;
        tag_d        = tag_q;
        err_d        = err_q;
        timer_d      = timer_q;

        op          = lsu_op_e'(req_op_i);
        aw_done     = !awvalid_q || awready_i;
        w_done      = !wvalid_q || wready_i;
        beat        = (rready_q && rvalid_i) || (bready_q && bvalid_i);
        timeout_hit = (TIMEOUT > 0) && (timer_q == TMR_LAST);
        r_err       = (rresp_i == AXI_RESP_SLVERR) || (rresp_i == AXI_RESP_DECERR);
        b_err       = (bresp_i == AXI_RESP_SLVERR) || (bresp_i == AXI_RESP_DECERR);

        if ((TIMEOUT > 0) && (state_q == ST_RDATA || state_q == ST_WRESP))
            timer_d = timer_q + 1'b1;

        unique case (state_q)
            ST_IDLE: if (req_valid_i) begin
                size_d      = req_size_i;
                uns_d       = req_unsigned_i;
                addr_d      = req_addr_i;
                wdata_d     = req_wdata_i;
                tag_d       = req_tag_i;
                req_ready_d = 1'b0;
                if ((op == LSU_OP_LOAD || op == LSU_OP_STORE) &&
                    lsu_misaligned(req_size_i, req_addr_i[2:0], DATA_W == 64)) begin
                    state_d      = ST_RESP;
                    resp_valid_d = 1'b1;
                    data_d       = '0;
                    err_d        = LSU_ERR_MISALIGN;
                end else if (op == LSU_OP_LOAD) begin
                    state_d   = ST_RADDR;
                    arvalid_d = 1'b1;
                end else if (op == LSU_OP_STORE) begin
                    state_d   = ST_WREQ;
                    awvalid_d = 1'b1;
                    wvalid_d  = 1'b1;
                end else begin
                    state_d      = ST_RESP;
                    resp_valid_d = 1'b1;
                    data_d       = req_result_i;
                    err_d        = LSU_ERR_OK;
                end
            end
            ST_RADDR: if (arready_i) begin
                arvalid_d = 1'b0;
                rready_d  = 1'b1;
                timer_d   = '0;
                state_d   = ST_RDATA;
            end
            ST_RDATA: begin
                if (rvalid_i) begin
                    rready_d     = 1'b0;
                    resp_valid_d = 1'b1;
                    data_d       = r_err ? '0 : ld_data;
                    err_d        = r_err ? LSU_ERR_BUS : LSU_ERR_OK;
                    state_d      = ST_RESP;
                end else if (timeout_hit) begin
                    resp_valid_d = 1'b1;
                    data_d       = '0;
                    err_d        = LSU_ERR_TIMEOUT;
                    state_d      = ST_RESP;
                end
            end
            ST_WREQ: begin
                awvalid_d = awvalid_q && !awready_i;
                wvalid_d  = wvalid_q && !wready_i;
                if (aw_done && w_done) begin
                    bready_d = 1'b1;
                    timer_d  = '0;
                    state_d  = ST_WRESP;
                end
            end
            ST_WRESP: begin
                if (bvalid_i) begin
                    bready_d     = 1'b0;
                    resp_valid_d = 1'b1;
                    data_d       = '0;
                    err_d        = b_err ? LSU_ERR_BUS : LSU_ERR_OK;
                    state_d      = ST_RESP;
                end else if (timeout_hit) begin
                    resp_valid_d = 1'b1;
                    data_d       = '0;
                    err_d        = LSU_ERR_TIMEOUT;
                    state_d      = ST_RESP;
                end
            end
            // rready/bready still high here only after a timeout; dropping it
            // records that the late beat was consumed and no drain is needed
            ST_RESP: begin
                if (beat) begin
                    rready_d = 1'b0;
                    bready_d = 1'b0;
                end
                if (resp_ready_i) begin
                    resp_valid_d = 1'b0;
                    if ((rready_q || bready_q) && !beat) begin
                        state_d = ST_DRAIN;
                    end else begin
                        state_d     = ST_IDLE;
                        req_ready_d = 1'b1;
                    end
                end
            end
            ST_DRAIN: if (beat) begin
                rready_d    = 1'b0;
                bready_d    = 1'b0;
                req_ready_d = 1'b1;
                state_d     = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            req_ready_q  <= 1'b1;
            arvalid_q    <= 1'b0;
            rready_q     <= 1'b0;
            awvalid_q    <= 1'b0;
            wvalid_q     <= 1'b0;
            bready_q     <= 1'b0;
            resp_valid_q <= 1'b0;
            size_q       <= '0;
            uns_q        <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            data_q       <= '0;
            tag_q        <= '0;
            err_q        <= LSU_ERR_OK;
            timer_q      <= '0;
        end else begin
            state_q      <= state_d;
            req_ready_q  <= req_ready_d;
            arvalid_q    <= arvalid_d;
            rready_q     <= rready_d;
            awvalid_q    <= awvalid_d;
            wvalid_q     <= wvalid_d;
            bready_q     <= bready_d;
            resp_valid_q <= resp_valid_d;
            size_q       <= size_d;
            uns_q        <= uns_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            data_q       <= data_d;
            tag_q        <= tag_d;
            err_q        <= err_d;
            timer_q      <= timer_d;
        end
    end

    assign req_ready_o  = req_ready_q;
    assign resp_valid_o = resp_valid_q;
    assign resp_data_o  = data_q;
    assign resp_tag_o   = tag_q;
    assign resp_err_o   = err_q;
    assign araddr_o     = addr_q & ~ADDR_W'(STRB_W - 1);
    assign awaddr_o     = addr_q & ~ADDR_W'(STRB_W - 1);
    assign arvalid_o    = arvalid_q;
    assign rready_o     = rready_q;
    assign awvalid_o    = awvalid_q;
    assign wvalid_o     = wvalid_q;
    assign bready_o     = bready_q;

endmodule

// File: tb/tb_lsu_axi.sv
// Bench for lsu_axi (32-bit bus, TIMEOUT=8): directed plan items plus random
// transactions checked against an arithmetic reference model.
module tb_lsu_axi;

    logic         clock = 1'b0;
    logic         reset = 1'b1;
    logic         req_valid_i = 1'b0, req_ready_o;
    logic [1:0]   req_op_i = '0, req_size_i = '0;
    logic         req_unsigned_i = 1'b0;
    logic [31:0]  req_addr_i = '0, req_wdata_i = '0, req_result_i = '0;
    logic [118:0] req_tag_i = '0, resp_tag_o;
    logic         resp_valid_o, resp_ready_i = 1'b0;
    logic [31:0]  resp_data_o;
    logic [1:0]   resp_err_o;
    logic [31:0]  araddr_o, awaddr_o, wdata_o, rdata_i = '0;
    logic         arvalid_o, arready_i = 1'b0;
    logic [1:0]   rresp_i = '0, bresp_i = '0;
    logic         rvalid_i = 1'b0, rready_o;
    logic         awvalid_o, awready_i = 1'b0;
    logic [3:0]   wstrb_o;
    logic         wvalid_o, wready_i = 1'b0;
    logic         bvalid_i = 1'b0, bready_o;

    int unsigned checks = 0;
    int unsigned errors = 0;

    lsu_axi #(.DATA_W(32), .ADDR_W(32), .TAG_W(119), .TIMEOUT(8)) dut (
        .clock(clock), .reset(reset),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_op_i(req_op_i),
        .req_size_i(req_size_i), .req_unsigned_i(req_unsigned_i), .req_addr_i(req_addr_i),
        .req_wdata_i(req_wdata_i), .req_result_i(req_result_i), .req_tag_i(req_tag_i),
        .resp_valid_o(resp_valid_o), .resp_ready_i(resp_ready_i), .resp_data_o(resp_data_o),
        .resp_tag_o(resp_tag_o), .resp_err_o(resp_err_o),
        .araddr_o(araddr_o), .arvalid_o(arvalid_o), .arready_i(arready_i),
        .rdata_i(rdata_i), .rresp_i(rresp_i), .rvalid_i(rvalid_i), .rready_o(rready_o),
        .awaddr_o(awaddr_o), .awvalid_o(awvalid_o), .awready_i(awready_i),
        .wdata_o(wdata_o), .wstrb_o(wstrb_o), .wvalid_o(wvalid_o), .wready_i(wready_i),
        .bresp_i(bresp_i), .bvalid_i(bvalid_i), .bready_o(bready_o)
    );

    always #5 clock = ~clock;

    initial begin
        #2000000;
        $display("FAIL watchdog: observed=running expected=finished");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    // Reference model: byte lanes and extension computed arithmetically.
    function automatic logic [31:0] m_load(input logic [31:0] addr, input logic [1:0] size,
                                           input logic uns, input logic [31:0] rd);
        longint unsigned mask, v;
        int unsigned nb;
        nb   = 1 << size;
        mask = (64'd1 << (8 * nb)) - 1;
        v    = ({32'b0, rd} >> (8 * (addr % 4))) & mask;
        if (!uns && ((v >> (8 * nb - 1)) & 1) == 1) v = v | ~mask;
        return v[31:0];
    endfunction

    function automatic logic [31:0] m_wdata(input logic [31:0] d, input int unsigned nb);
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < 4; i++) r = r | (((d >> (8 * (i % nb))) & 32'hFF) << (8 * i));
        return r;
    endfunction

    task automatic run_txn(input logic [1:0] op, input logic [1:0] size, input logic uns,
                           input logic [31:0] addr, input logic [31:0] wd, input logic [31:0] res,
                           input logic [118:0] tag, input logic [31:0] rd, input logic [1:0] rr,
                           input int unsigned ar_d, input int unsigned r_d,
                           input int unsigned aw_d, input int unsigned w_d,
                           input int unsigned b_d, input logic [1:0] br,
                           input int unsigned rsp_d);
        int unsigned nb, m;
        logic        mis;
        logic [31:0] exp_data;
        logic [1:0]  exp_err;
        nb  = 1 << size;
        mis = (op == 2'b01 || op == 2'b10) && (size == 2'd3 || (addr % nb) != 0);

        check("req_ready_idle", req_ready_o, 1);
        req_valid_i = 1'b1; req_op_i = op; req_size_i = size; req_unsigned_i = uns;
        req_addr_i = addr; req_wdata_i = wd; req_result_i = res; req_tag_i = tag;
        @(negedge clock);
        req_valid_i = 1'b0;
        check("req_ready_busy", req_ready_o, 0);

        if (mis || !(op == 2'b01 || op == 2'b10)) begin
            exp_data = mis ? 32'h0 : res;
            exp_err  = mis ? 2'b01 : 2'b00;
        end else if (op == 2'b01) begin
            for (int unsigned c = 0; c <= ar_d; c++) begin
                check("arvalid", arvalid_o, 1);
                check("araddr", araddr_o, addr & ~32'h3);
                arready_i = (c == ar_d);
                @(negedge clock);
            end
            arready_i = 1'b0;
            check("arvalid_drop", arvalid_o, 0);
            for (int unsigned c = 0; c <= r_d; c++) begin
                check("rready", rready_o, 1);
                check("resp_early_r", resp_valid_o, 0);
                if (c == r_d) begin rvalid_i = 1'b1; rdata_i = rd; rresp_i = rr; end
                @(negedge clock);
            end
            rvalid_i = 1'b0;
            check("rready_drop", rready_o, 0);
            exp_data = rr[1] ? 32'h0 : m_load(addr, size, uns, rd);
            exp_err  = rr[1] ? 2'b10 : 2'b00;
        end else begin
            m = (aw_d > w_d) ? aw_d : w_d;
            for (int unsigned c = 0; c <= m; c++) begin
                check("awvalid", awvalid_o, c <= aw_d);
                check("wvalid", wvalid_o, c <= w_d);
                check("bready_early", bready_o, 0);
                if (c <= aw_d) check("awaddr", awaddr_o, addr & ~32'h3);
                if (c <= w_d) begin
                    check("wdata", wdata_o, m_wdata(wd, nb));
                    check("wstrb", wstrb_o, ((32'd1 << nb) - 1) << (addr % 4));
                end
                awready_i = (c == aw_d);
                wready_i  = (c == w_d);
                @(negedge clock);
            end
            awready_i = 1'b0; wready_i = 1'b0;
            check("aw_w_done", {awvalid_o, wvalid_o}, 2'b00);
            for (int unsigned c = 0; c <= b_d; c++) begin
                check("bready", bready_o, 1);
                check("resp_early_b", resp_valid_o, 0);
                if (c == b_d) begin bvalid_i = 1'b1; bresp_i = br; end
                @(negedge clock);
            end
            bvalid_i = 1'b0;
            check("bready_drop", bready_o, 0);
            exp_data = 32'h0;
            exp_err  = br[1] ? 2'b10 : 2'b00;
        end

        for (int unsigned c = 0; c <= rsp_d; c++) begin
            check("resp_valid", resp_valid_o, 1);
            check("resp_data", resp_data_o, exp_data);
            check("resp_err", resp_err_o, exp_err);
            check("resp_tag", resp_tag_o, tag);
            check("resp_req_ready", req_ready_o, 0);
            check("resp_no_bus", {arvalid_o, awvalid_o, wvalid_o}, 3'b000);
            resp_ready_i = (c == rsp_d);
            @(negedge clock);
        end
        resp_ready_i = 1'b0;
        check("resp_done", resp_valid_o, 0);
        check("req_ready_back", req_ready_o, 1);
    endtask

    // Issues an aligned lw, completes AR, and lets the 8-cycle timeout expire.
    task automatic start_timeout(input logic [118:0] tag);
        req_valid_i = 1'b1; req_op_i = 2'b01; req_size_i = 2'd2; req_unsigned_i = 1'b0;
        req_addr_i = 32'h8000_0010; req_tag_i = tag;
        @(negedge clock);
        req_valid_i = 1'b0;
        arready_i = 1'b1;
        @(negedge clock);
        arready_i = 1'b0;
        for (int k = 0; k < 8; k++) begin
            check("to_wait", resp_valid_o, 0);
            @(negedge clock);
        end
        check("to_valid", resp_valid_o, 1);
        check("to_err", resp_err_o, 2'b11);
        check("to_data", resp_data_o, 0);
        check("to_rready", rready_o, 1);
    endtask

    initial begin
        logic [1:0]  op, sz, lo;
        logic [31:0] a;

        repeat (3) @(negedge clock);
        check("rst_req_ready", req_ready_o, 1);
        check("rst_valids", {arvalid_o, rready_o, awvalid_o, wvalid_o, bready_o, resp_valid_o}, 6'b0);
        check("rst_err", resp_err_o, 2'b00);
        check("rst_data", resp_data_o, 0);
        check("rst_tag", resp_tag_o, 0);
        reset = 1'b0;
        @(negedge clock);

        // op none, 1-cycle latency
        run_txn(2'b00, 2'd2, 1'b0, 32'h0, 32'h0, 32'hDEADBEEF, 119'h5A, 32'h0, 2'b00,
                0, 0, 0, 0, 0, 2'b00, 0);
        // lb signed / unsigned from lane 3
        run_txn(2'b01, 2'd0, 1'b0, 32'h8000_0003, 32'h0, 32'h0, 119'h11, 32'h80FF_0000, 2'b00,
                1, 2, 0, 0, 0, 2'b00, 0);
        run_txn(2'b01, 2'd0, 1'b1, 32'h8000_0003, 32'h0, 32'h0, 119'h12, 32'h80FF_0000, 2'b00,
                0, 0, 0, 0, 0, 2'b00, 1);
        // sh, awready three cycles before wready
        run_txn(2'b10, 2'd1, 1'b0, 32'h8000_0002, 32'h1234, 32'h0, 119'h13, 32'h0, 2'b00,
                0, 0, 0, 3, 1, 2'b00, 0);
        // misaligned lw, then lw with SLVERR
        run_txn(2'b01, 2'd2, 1'b0, 32'h8000_0001, 32'h0, 32'h0, 119'h14, 32'h0, 2'b00,
                0, 0, 0, 0, 0, 2'b00, 0);
        run_txn(2'b01, 2'd2, 1'b0, 32'h8000_0004, 32'h0, 32'h0, 119'h15, 32'hCAFEF00D, 2'b10,
                0, 1, 0, 0, 0, 2'b00, 0);
        // held response: 10 stall cycles
        run_txn(2'b10, 2'd2, 1'b0, 32'h8000_0008, 32'hA5A5_1234, 32'h0, 119'h16, 32'h0, 2'b00,
                0, 0, 2, 0, 2, 2'b11, 10);

        // timeout, late beat consumed in DRAIN
        start_timeout(119'h17);
        resp_ready_i = 1'b1;
        @(negedge clock);
        resp_ready_i = 1'b0;
        for (int k = 0; k < 4; k++) begin
            check("drain_req_ready", req_ready_o, 0);
            check("drain_resp", resp_valid_o, 0);
            check("drain_rready", rready_o, 1);
            @(negedge clock);
        end
        rvalid_i = 1'b1; rdata_i = 32'h1357_9BDF; rresp_i = 2'b00;
        @(negedge clock);
        rvalid_i = 1'b0;
        check("drain_exit_ready", req_ready_o, 1);
        check("drain_exit_rready", rready_o, 0);

        // timeout, late beat arrives while response is still pending
        start_timeout(119'h18);
        rvalid_i = 1'b1; rdata_i = 32'h2468_ACE0;
        @(negedge clock);
        rvalid_i = 1'b0;
        check("late_rready", rready_o, 0);
        check("late_resp_err", resp_err_o, 2'b11);
        check("late_resp_valid", resp_valid_o, 1);
        resp_ready_i = 1'b1;
        @(negedge clock);
        resp_ready_i = 1'b0;
        check("late_idle", req_ready_o, 1);

        // reset in the middle of a store
        req_valid_i = 1'b1; req_op_i = 2'b10; req_size_i = 2'd2; req_addr_i = 32'h8000_0020;
        @(negedge clock);
        req_valid_i = 1'b0;
        check("mid_wreq", {awvalid_o, wvalid_o}, 2'b11);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        check("rst_mid_valids", {arvalid_o, awvalid_o, wvalid_o, bready_o, resp_valid_o}, 5'b0);
        check("rst_mid_ready", req_ready_o, 1);
        reset = 1'b0;
        @(negedge clock);

        for (int n = 0; n < 60; n++) begin
            op = 2'($urandom_range(0, 3));
            sz = 2'($urandom_range(0, 3));
            lo = ($urandom_range(0, 1) == 0) ? 2'b00 : 2'($urandom_range(0, 3));
            a  = {$urandom() & 32'hFFFF_FFFC} | {30'b0, lo};
            run_txn(op, sz, 1'($urandom_range(0, 1)), a, $urandom(), $urandom(),
                    {$urandom(), $urandom(), $urandom(), $urandom()} >> 9,
                    $urandom(), 2'($urandom_range(0, 3)),
                    $urandom_range(0, 3), $urandom_range(0, 4),
                    $urandom_range(0, 3), $urandom_range(0, 3),
                    $urandom_range(0, 4), 2'($urandom_range(0, 3)),
                    $urandom_range(0, 2));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
